// File: rtl/burst_wf_pkg.sv
// burst_wf_pkg: FSM state encoding and byte-enable constant shared by the burst masters
package burst_wf_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } state_t;
    localparam int MAX_BE_WIDTH = 128;
    localparam logic [MAX_BE_WIDTH-1:0] BE_ALL_ONES = '1;
endpackage

// File: rtl/burst_read_wf_if.sv
// burst_read_wf_if: Avalon-MM read master bus plus local buffer control/stream signals
interface burst_read_wf_if #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_WIDTH       = 2
);
    logic [ADDRESS_WIDTH-1:0]     master_address;
    logic                         master_read;
    logic [BURST_WIDTH-1:0]       master_burstcount;
    logic [BYTE_ENABLE_WIDTH-1:0] master_byteenable;
    logic                         master_waitrequest;
    logic [DATA_WIDTH-1:0]        master_readdata;
    logic                         master_readdatavalid;
    logic                         ctrl_start;
    logic [ADDRESS_WIDTH-1:0]     ctrl_baseaddress;
    logic [BURST_WIDTH-1:0]       ctrl_burstcount;
    logic                         ctrl_busy;
    logic [BURST_WIDTH-1:0]       ctrl_address;
    logic [DATA_WIDTH-1:0]        ctrl_readdata;
    logic                         ctrl_write;
    logic                         ctrl_done;
    modport master (
        output master_address, master_read, master_burstcount, master_byteenable,
        output ctrl_busy, ctrl_address, ctrl_readdata, ctrl_write, ctrl_done,
        input  master_waitrequest, master_readdata, master_readdatavalid,
        input  ctrl_start, ctrl_baseaddress, ctrl_burstcount
    );
    modport slave (
        input  master_address, master_read, master_burstcount, master_byteenable,
        input  ctrl_busy, ctrl_address, ctrl_readdata, ctrl_write, ctrl_done,
        output master_waitrequest, master_readdata, master_readdatavalid,
        output ctrl_start, ctrl_baseaddress, ctrl_burstcount
    );
endinterface

// File: rtl/burst_read_wf.sv
// burst_read_wf: Avalon-MM burst read master streaming returned beats to a local buffer
module burst_read_wf
    import burst_wf_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int DATA_WIDTH        = 32,
    parameter int BYTE_ENABLE_WIDTH = 4,
    parameter int BURST_COUNT       = 2,
    parameter int BURST_WIDTH       = 2
) (
    input logic             clk,
    input logic             reset,
    burst_read_wf_if.master bus
);
    if (BYTE_ENABLE_WIDTH * 8 != DATA_WIDTH || BYTE_ENABLE_WIDTH > MAX_BE_WIDTH ||
        BURST_COUNT < 1 || BURST_COUNT > (1 << BURST_WIDTH) - 1) begin : g_bad_params
        $error("burst_read_wf: inconsistent parameters");
    end
    state_t                   r_state;
    logic [BURST_WIDTH-1:0]   r_cnt;
    logic [BURST_WIDTH-1:0]   r_len;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [BURST_WIDTH-1:0]   r_bc;
    logic                     r_read;
    logic                     r_busy;
    logic                     r_done;
    logic                     w_beat;
    logic                     w_last;
    assign w_beat = bus.master_readdatavalid && r_state == ST_DATA;
    assign w_last = r_cnt == r_len - BURST_WIDTH'(1);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_addr  <= '0;
            r_bc    <= '0;
            r_read  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: if (bus.ctrl_start && bus.ctrl_burstcount != '0) begin
                    r_addr  <= bus.ctrl_baseaddress;
                    r_bc    <= bus.ctrl_burstcount;
                    r_len   <= bus.ctrl_burstcount;
                    r_cnt   <= '0;
                    r_read  <= 1'b1;
                    r_busy  <= 1'b1;
                    r_state <= ST_REQ;
                end
                ST_REQ: if (!bus.master_waitrequest) begin
                    r_read  <= 1'b0;
                    r_state <= ST_DATA;
                end
                ST_DATA: if (w_beat) begin
                    // terminate on the latched length so a full BURST_COUNT burst never wraps
                    r_cnt   <= w_last ? '0 : r_cnt + BURST_WIDTH'(1);
                    r_busy  <= !w_last;
                    r_done  <= w_last;
                    r_state <= w_last ? ST_DONE : ST_DATA;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    assign bus.master_address    = r_addr;
    assign bus.master_read       = r_read;
    assign bus.master_burstcount = r_bc;
    assign bus.master_byteenable = BE_ALL_ONES[BYTE_ENABLE_WIDTH-1:0];
    assign bus.ctrl_busy         = r_busy;
    assign bus.ctrl_done         = r_done;
    assign bus.ctrl_address      = r_cnt;
    assign bus.ctrl_readdata     = bus.master_readdata;
    assign bus.ctrl_write        = w_beat;
endmodule

// File: doc/burst_read_wf.md
Name: burst_read_wf

Overview:
- Avalon-MM burst read master; the read-side counterpart of the team's burst write master.
- On ctrl_start it issues one burst read of ctrl_burstcount beats at ctrl_baseaddress.
- Collects the pipelined read data beats (master_readdatavalid) and streams each beat to a local buffer with a beat index.
- Sits between the SDRAM/Avalon interconnect and a local on-chip buffer, e.g. the frame line buffer feeding processing.

Parameters:
ADDRESS_WIDTH, 32, Avalon word-address width
DATA_WIDTH, 32, read data width (16..1024)
BYTE_ENABLE_WIDTH, 4, DATA_WIDTH/8
BURST_COUNT, 2, maximum beats per burst (power of 2, 1..1024)
BURST_WIDTH, 2, width of burstcount and beat index; must hold BURST_COUNT

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
master_address  out  ADDRESS_WIDTH  burst start address
master_read  out  1  read request
master_burstcount  out  BURST_WIDTH  beats requested
master_byteenable  out  BYTE_ENABLE_WIDTH  constant all ones
master_waitrequest  in  1  slave stall
master_readdata  in  DATA_WIDTH  returned beat
master_readdatavalid  in  1  returned beat valid
ctrl_start  in  1  start request, sampled when idle
ctrl_baseaddress  in  ADDRESS_WIDTH  burst address
ctrl_burstcount  in  BURST_WIDTH  beats, 1..BURST_COUNT
ctrl_busy  out  1  transaction in progress
ctrl_address  out  BURST_WIDTH  beat index of current ctrl_readdata
ctrl_readdata  out  DATA_WIDTH  beat data to local buffer
ctrl_write  out  1  local buffer write strobe
ctrl_done  out  1  one-cycle pulse after last beat stored

Behaviour:
- Reset (reset=0, async):
  - state IDLE; beat counter 0; latched count 0.
  - master_address, master_burstcount, master_read, ctrl_busy and ctrl_done all 0.
  - Beats arriving after reset deasserts that belong to an aborted burst are ignored while IDLE.
- FSM states: IDLE, REQ, DATA, DONE.
- IDLE:
  - ctrl_start=1 and ctrl_burstcount!=0 -> REQ next cycle.
  - On that edge: register master_address=ctrl_baseaddress, master_burstcount=ctrl_burstcount, latched count=ctrl_burstcount; master_read=1; ctrl_busy=1; beat counter=0.
  - ctrl_start with count 0 is ignored: stay IDLE, no bus activity.
- REQ:
  - master_read held with address/burstcount stable while master_waitrequest=1.
  - First cycle with master_waitrequest=0 accepts the command: master_read=0 next cycle, go to DATA.
- DATA:
  - Each cycle with master_readdatavalid=1 is one beat: ctrl_write=1, ctrl_readdata=master_readdata, ctrl_address=beat counter (combinational passthrough, zero latency), then counter increments.
  - On the beat where counter == latched count-1: counter resets to 0, go to DONE.
- DONE:
  - ctrl_done=1 for exactly one cycle; ctrl_busy=0 in the same cycle; return to IDLE.
  - A new ctrl_start is accepted in the following IDLE cycle, so back-to-back bursts have a 1-cycle minimum gap after DONE.
- Readdatavalid in the same cycle the command is accepted in REQ: illegal per Avalon, ignored (the slave cannot return data before accepting).
- Readdatavalid in IDLE/DONE: ctrl_write stays 0.
- ctrl_write = master_readdatavalid AND state==DATA; ctrl_address = beat counter in all states.
- ctrl_start while busy is ignored; ctrl_baseaddress and ctrl_burstcount are only sampled in IDLE.
- Gaps between valid beats of any length are tolerated. There is no timeout.
- Counter arithmetic is BURST_WIDTH-bit unsigned; the last-beat compare uses the latched count, so a burst of BURST_COUNT beats never needs counter wrap.
- Single outstanding burst only: no new command is issued until the previous burst's data is complete.

Decomposition:
- Shared package burst_wf_pkg holds the FSM state encoding (IDLE/REQ/DATA/DONE, 2-bit) and the all-ones byte-enable constant, also used by the write master.
- No sub-module; a single flat module.

Test Plan:
- Start at addr 0x100, count 2, waitrequest low, valid on cycles +2 and +3 with data 0xA5A5A5A5 and 0x5A5A5A5A -> master_read high exactly 1 cycle with address 0x100 and burstcount 2; ctrl_write at index 0 then 1 with the matching data; ctrl_done 1 cycle later; busy drops with done.
- waitrequest high for 3 cycles during REQ -> address, burstcount and read held stable for 4 cycles, single command accepted, data phase proceeds normally.
- Count 2 with beats separated by a 5-cycle valid gap -> exactly 2 ctrl_write strobes at indices 0,1; busy high throughout the gap.
- ctrl_start with count 0, and ctrl_start pulsed while busy -> no master_read and no state change; busy unaffected.
- Reset asserted mid-DATA after beat 0, then a stray valid beat after release -> all outputs 0 immediately; stray beat produces no ctrl_write; the next start at 0x200 runs cleanly.
- Two back-to-back bursts (0x000 then 0x002, count 2) -> second master_read asserts 2 cycles after the first ctrl_done cycle; indices restart at 0.
